// File: rtl/freq_ascii_formatter.sv
// Latches a binary count, converts it to BCD by sequential double-dabble and streams
// "CR LF <digits> Hz" to UART_TX. Define FREQ_FMT_ZERO_SUPPRESS_EN to drop leading zeros.
module freq_ascii_formatter #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_DIGITS  = 10
) (
    input  logic                   clk,
    input  logic                   i_Rst_L,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_busy,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Done,
    output logic                   o_done
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int NB = NUM_DIGITS + 5;
    localparam int IW = $clog2(NB);
    localparam int CW = $clog2(COUNT_WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NB - 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(COUNT_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SEND, S_WAIT} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] shift_reg;
    logic [BW-1:0]          bcd;
    logic [CW-1:0]          shift_cnt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          first_digit;
    logic [IW-1:0]          next_idx;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit.
    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b, input logic in_bit);
        logic [BW-1:0] a;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            a[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        end
        return {a[BW-2:0], in_bit};
    endfunction

    // Byte index layout: 0 CR, 1 LF, 2..NUM_DIGITS+1 digits (MSD first), then ' ', 'H', 'z'.
    function automatic logic [7:0] byte_for(input logic [IW-1:0] i, input logic [BW-1:0] b);
        int d;
        d = int'(i) - 2;
        if (d == -2)
            return 8'h0D;
        else if (d == -1)
            return 8'h0A;
        else if (d < NUM_DIGITS)
            return 8'h30 + {4'h0, b[4*(NUM_DIGITS-1-d) +: 4]};
        else if (d == NUM_DIGITS)
            return 8'h20;
        else if (d == NUM_DIGITS + 1)
            return 8'h48;
        else
            return 8'h7A;
    endfunction

    always_comb begin
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        // Scan from the least significant digit up so the most significant non-zero wins.
        first_digit = IW'(NUM_DIGITS + 1);
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (bcd[4*(NUM_DIGITS-1-k) +: 4] != 4'd0)
                first_digit = IW'(k + 2);
        end
`else
        first_digit = IW'(2);
`endif
        next_idx = (idx == IW'(1)) ? first_digit : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            idx       <= '0;
            o_busy    <= 1'b0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
            o_done    <= 1'b0;
        end else begin
            o_TX_DV <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        shift_reg <= i_count;
                        bcd       <= '0;
                        shift_cnt <= '0;
                        o_busy    <= 1'b1;
                        state     <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    shift_reg <= {shift_reg[COUNT_WIDTH-2:0], 1'b0};
                    bcd       <= dabble(bcd, shift_reg[COUNT_WIDTH-1]);
                    shift_cnt <= shift_cnt + 1'b1;
                    // The first byte is always CR, so it can be issued with the last shift.
                    if (shift_cnt == LAST_SHIFT) begin
                        idx       <= '0;
                        o_TX_Byte <= 8'h0D;
                        o_TX_DV   <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_TX_Done) begin
                        if (idx == LAST_IDX) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            idx       <= next_idx;
                            o_TX_Byte <= byte_for(next_idx, bcd);
                            o_TX_DV   <= 1'b1;
                            state     <= S_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_ascii_formatter.sv
// Scoreboard bench for freq_ascii_formatter: expected bytes are queued at stimulus time and
// a forked monitor pops and compares on every o_TX_DV; a forked responder plays UART_TX.
module tb_freq_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] count;
    logic        tx_done;
    logic        busy;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          dv_seen = 0;
    int          done_delay = 3;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_byte;
    bit          have_last = 0;

    freq_ascii_formatter #(.COUNT_WIDTH(32), .NUM_DIGITS(10)) dut (
        .clk       (clk),
        .i_Rst_L   (rst_n),
        .i_start   (start),
        .i_count   (count),
        .o_busy    (busy),
        .o_TX_DV   (tx_dv),
        .o_TX_Byte (tx_byte),
        .i_TX_Done (tx_done),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_line(input string digits);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h7A);
    endtask

    task automatic start_line(input logic [31:0] c);
        @(negedge clk);
        start = 1'b1;
        count = c;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_capture", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_dv(input int n);
        int t;
        for (t = 0; t < 3000 && dv_seen < n; t++) @(negedge clk);
        if (dv_seen < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_dv: saw %0d DVs, needed %0d", dv_seen, n);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        for (t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (done) break;
        end
        if (t == 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: o_done 0, expected pulse", name);
        end else begin
            chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
            chk({name, " bytes_left"}, exp_q.size(), 32'd0);
            @(negedge clk);
            chk({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int base;
        rst_n   = 1'b0;
        start   = 1'b0;
        count   = '0;
        tx_done = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    have_last = 0;
                end else if (tx_dv) begin
                    dv_seen++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_dv: got byte %h, none expected", tx_byte);
                    end else begin
                        chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                    end
                    last_byte = tx_byte;
                    have_last = 1;
                end else if (busy && have_last) begin
                    chk("byte_hold", {24'd0, tx_byte}, {24'd0, last_byte});
                end
            end
            forever begin
                if (rst_n && tx_dv) begin
                    repeat (done_delay) @(negedge clk);
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
        join_none

        #3;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst dv", {31'd0, tx_dv}, 32'd0);
        chk("rst byte", {24'd0, tx_byte}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-width line with a slow UART
        done_delay = 100;
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("12345678");
`else
        push_line("0012345678");
`endif
        start_line(32'd12345678);
        wait_done("t1_12345678");

        // Maximum value and first-DV latency
        done_delay = 3;
        push_line("4294967295");
        start_line(32'hFFFF_FFFF);
        n = 0;
        while (!tx_dv && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2 first_dv_latency", n, 32'd32);
        wait_done("t2_max");

        // Zero value
        base = dv_seen;
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("0");
`else
        push_line("0000000000");
`endif
        start_line(32'd0);
        wait_done("t3_zero");
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        chk("t3 dv_count", dv_seen - base, 32'd6);
`else
        chk("t3 dv_count", dv_seen - base, 32'd15);
`endif

        // Interior zeros survive suppression
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("1000");
`else
        push_line("0000001000");
`endif
        start_line(32'd1000);
        wait_done("t4_1000");

        // Ignored events: Done in IDLE and CONVERT, start during WAIT
        base = dv_seen;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5 idle_done busy", {31'd0, busy}, 32'd0);
        chk("t5 idle_done no_dv", dv_seen - base, 32'd0);
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("42");
`else
        push_line("0000000042");
`endif
        start_line(32'd42);
        repeat (5) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        done_delay = 20;
        wait_dv(base + 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        count = 32'd99;
        @(negedge clk);
        start = 1'b0;
        chk("t5 busy_after_restart", {31'd0, busy}, 32'd1);
        wait_done("t5_42");
        done_delay = 3;

        // Reset during the 5th byte's WAIT
        base = dv_seen;
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("7");
`else
        push_line("0000000007");
`endif
        start_line(32'd7);
        wait_dv(base + 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async busy", {31'd0, busy}, 32'd0);
        chk("t6 async dv", {31'd0, tx_dv}, 32'd0);
        chk("t6 async byte", {24'd0, tx_byte}, 32'd0);
        chk("t6 async done", {31'd0, done}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
`ifdef FREQ_FMT_ZERO_SUPPRESS_EN
        push_line("555");
`else
        push_line("0000000555");
`endif
        start_line(32'd555);
        wait_done("t6_after_reset");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_ascii_formatter.md
# freq_ascii_formatter

Upstream feeder for the UART transmitter in the frequency counter. On each start request it latches a binary frequency count, converts it to decimal using sequential double-dabble, and streams the ASCII line `CR LF <digits> " Hz"` one byte at a time. Transmission uses the UART_TX data-valid/done handshake. It replaces the fixed-text source with a live measurement readout.

## Interface
- `COUNT_WIDTH`, default 32: width of the measured count.
- `NUM_DIGITS`, default 10: decimal digits produced. It must satisfy 10^NUM_DIGITS > 2^COUNT_WIDTH − 1. This is not checked in RTL.
- `clk` in 1: single clock; all state is on the rising edge.
- `i_Rst_L` in 1: reset, asynchronous, active-low.
- `i_start` in 1: capture request, sampled only in IDLE.
- `i_count` in COUNT_WIDTH: count to print, sampled on the same edge as `i_start`.
- `o_busy` out 1: high from the capture edge until the edge that ends the line.
- `o_TX_DV` out 1: one-cycle byte-valid pulse to UART_TX.
- `o_TX_Byte` out 8: byte for UART_TX. Stable from the DV cycle until the next DV.
- `i_TX_Done` in 1: one-cycle byte-complete pulse from UART_TX.
- `o_done` out 1: one-cycle pulse when the final byte completes.

## Operation
- **Reset values:** `o_busy`=0, `o_TX_DV`=0, `o_TX_Byte`=0x00, `o_done`=0. State is IDLE; shift, BCD and index registers are cleared.
- **IDLE**
  - On `i_start`=1: load the shift register with `i_count`, clear BCD (4·NUM_DIGITS bits), go to CONVERT.
- **CONVERT**
  - Runs exactly COUNT_WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {BCD, shift-reg} left by 1.
  - After the last shift, go to SEND with byte index 0.
- **Byte sequence:**
  - 0x0D, 0x0A.
  - NUM_DIGITS digits, most significant first, each 0x30+nibble.
  - 0x20, 0x48, 0x7A.
- **SEND** (one cycle)
  - Drive `o_TX_Byte` for the current index and pulse `o_TX_DV`=1.
  - Go to WAIT.
- **WAIT**
  - Hold the byte with `o_TX_DV`=0.
  - On `i_TX_Done`=1: if this was the last byte, go to IDLE; otherwise increment the index and go to SEND.
- **Line end:** on the final `i_TX_Done`, `o_done` pulses for one cycle and `o_busy` falls on the same edge.
- **Ignored inputs:**
  - `i_start` outside IDLE, including a new start arriving during a transfer.
  - `i_TX_Done` outside WAIT.
  - `i_count` outside the capture edge.
- **Reset during operation:** all outputs return to their reset values immediately. Any partial line is abandoned. UART_TX shares `i_Rst_L`.

## Timing
- Capture happens on edge E0; `o_busy`=1 after E0.
- Shifts occur on E1..E_COUNT_WIDTH.
- The first `o_TX_DV` is visible after E_COUNT_WIDTH, i.e. COUNT_WIDTH cycles after `o_busy` rises.
- The next `o_TX_DV` follows `i_TX_Done` by exactly one cycle.
- There is never more than one DV per Done.

## Configuration
- Macro: `FREQ_FMT_ZERO_SUPPRESS_EN`.
- **Defined:**
  - Leading zero digits are skipped; the index jumps past them in SEND without a DV.
  - The least significant digit is always sent.
  - Line length is 5 + significant digits.
- **Undefined:** all NUM_DIGITS digits are sent. Line length is 5 + NUM_DIGITS (15 at default).

## Test plan
1. **Full-width line, suppression off.** Stimulus: macro undefined, `i_count`=12345678, Done returned 100 cycles after each DV. Response: 15 bytes 0D 0A 30 30 31 32 33 34 35 36 37 38 20 48 7A, then one `o_done` pulse.
2. **Maximum value.** Stimulus: `i_count`=0xFFFFFFFF. Response: digits 34 32 39 34 39 36 37 32 39 35; first DV exactly 32 cycles after `o_busy` rises.
3. **Zero value, both configurations.** Stimulus: `i_count`=0 with the macro defined. Response: 0D 0A 30 20 48 7A (6 DVs). With the macro undefined, ten 0x30 digits are sent.
4. **Zero suppression with interior zeros.** Stimulus: macro defined, `i_count`=1000. Response: 0D 0A 31 30 30 30 20 48 7A; the interior zeros are retained.
5. **Ignored events.** Stimulus: `i_start` with a different count while in WAIT; spurious `i_TX_Done` while in IDLE and CONVERT. Response: the line in progress is unchanged and no extra DV occurs.
6. **Reset mid-line.** Stimulus: drop `i_Rst_L` during the 5th byte's WAIT. Response: outputs go to 0 asynchronously. A following `i_start` produces a complete line beginning with 0x0D.
